mem_port_arbiter: RTL and testbench

- Shares the single 16-bit word memory port between up to NUM_REQ datapath requesters: reward/feedback builder, Q-value updater, packet forwarder, host loader.
- Grants are round-robin with bounded bursts and an optional lock for multi-word sequences such as a full feedback packet.
- Sits between the requesters and the memory. The memory has a 1-cycle synchronous read and a 1-cycle write.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_port_arbiter_rr_pick.sv | 31 +++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the datapath memory-port arbiter.
package mem_arb_pkg;

  localparam int unsigned ARB_WORD_WIDTH = 16;
  localparam int unsigned ARB_MAX_BURST  = 8;
  localparam int unsigned BURST_CNT_W    = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Requester slots on the shared port
  localparam int unsigned REQ_REWARD  = 0;
  localparam int unsigned REQ_QUPDATE = 1;
  localparam int unsigned REQ_FWD     = 2;
  localparam int unsigned REQ_HOST    = 3;

  // Memory region bases used by the requesters
  localparam logic [ARB_WORD_WIDTH-1:0] FB_BASE      = 16'h0048;
  localparam logic [ARB_WORD_WIDTH-1:0] QTAB_BASE    = 16'h0148;
  localparam logic [ARB_WORD_WIDTH-1:0] QTAB_HI_BASE = 16'h01C8;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first request above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic               valid_o
);

  logic [PTR_W-1:0] idx_c;
  logic             found_c;

  // Scan (ptr+1) .. (ptr+NUM_REQ) modulo NUM_REQ; the last slot is ptr itself
  always_comb begin
    win_o   = '0;
    found_c = 1'b0;
    idx_c   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx_c = PTR_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!found_c && req_i[idx_c]) begin
        win_o[idx_c] = 1'b1;
        found_c      = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous word memory port among requesters,
// with bounded bursts, optional lock and a one-cycle idle bubble between grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WORD_WIDTH = ARB_WORD_WIDTH,
  parameter int unsigned MAX_BURST  = ARB_MAX_BURST
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            lock_i,
  input  logic [NUM_REQ-1:0]            req_wr_i,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [WORD_WIDTH-1:0]         rdata_o,
  output logic [WORD_WIDTH-1:0]         mem_addr_o,
  output logic                          mem_wr_o,
  output logic [WORD_WIDTH-1:0]         mem_wdata_o,
  input  logic [WORD_WIDTH-1:0]         mem_rdata_i
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);
  localparam logic [BURST_CNT_W-1:0] BURST_SAT  = '1;

  arb_state_e               state_q, state_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [NUM_REQ-1:0]       rvalid_q, rvalid_d;
  logic [BURST_CNT_W-1:0]   burst_q, burst_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;

  logic [NUM_REQ-1:0]       pick_win_c;
  logic                     pick_valid_c;
  logic [PTR_W-1:0]         pick_idx_c;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .win_o   (pick_win_c),
    .valid_o (pick_valid_c)
  );

  // Convert the one-hot winner into an index for the pointer
  always_comb begin
    pick_idx_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_win_c[i]) pick_idx_c = PTR_W'(i);
    end
  end

  // Next-state: grant from IDLE, count accesses and release from BUSY
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    burst_d  = burst_q;
    rvalid_d = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          gnt_d   = pick_win_c;
          ptr_d   = pick_idx_c;
          burst_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!req_i[ptr_q]) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else begin
          rvalid_d[ptr_q] = ~req_wr_i[ptr_q];
          if (burst_q != BURST_SAT) burst_d = burst_q + BURST_CNT_W'(1);
          if (!lock_i[ptr_q] && (burst_q == BURST_LAST)) begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset leaves requester 0 with first priority
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rvalid_q <= '0;
      burst_q  <= '0;
      ptr_q    <= PTR_W'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      burst_q  <= burst_d;
      ptr_q    <= ptr_d;
    end
  end

  // Memory port follows the granted requester; quiet in IDLE and in reset
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wr_o    = 1'b0;
    if (!reset_i && (state_q == BUSY)) begin
      mem_addr_o  = req_addr_i[32'(ptr_q) * WORD_WIDTH +: WORD_WIDTH];
      mem_wdata_o = req_wdata_i[32'(ptr_q) * WORD_WIDTH +: WORD_WIDTH];
      mem_wr_o    = req_i[ptr_q] & req_wr_i[ptr_q];
    end
  end

  assign gnt_o    = gnt_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Cycle-table bench for mem_port_arbiter with a read-data scoreboard.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned WW = 16;
  localparam int unsigned MB = 2;

  typedef struct {
    logic          rst;
    logic [NR-1:0] req;
    logic [NR-1:0] lock;
    logic [NR-1:0] wr;
    logic [NR-1:0] gnt;
  } vec_t;

  typedef struct {
    int            due;
    int            who;
    logic [WW-1:0] data;
  } sb_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR-1:0]    req, lock, req_wr;
  logic [NR*WW-1:0] req_addr, req_wdata;
  logic [NR-1:0]    gnt, rvalid;
  logic [WW-1:0]    rdata, mem_addr, mem_wdata, mem_rdata;
  logic             mem_wr;

  logic [WW-1:0] addr_tab  [NR];
  logic [WW-1:0] wdata_tab [NR];
  logic [WW-1:0] mem       [0:511];
  logic [WW-1:0] exp_mem   [0:511];
  logic          mem_init;

  vec_t          vecs [$];
  sb_t           sb   [$];
  int            errors = 0;
  int            checks = 0;
  int            cyc    = 0;
  logic [NR-1:0] seen_gnt;
  int            first  [NR];

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .NUM_REQ    (NR),
    .WORD_WIDTH (WW),
    .MAX_BURST  (MB)
  ) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .req_i       (req),
    .lock_i      (lock),
    .req_wr_i    (req_wr),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .mem_addr_o  (mem_addr),
    .mem_wr_o    (mem_wr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  function automatic logic [WW-1:0] init_word(input int i);
    return (i == 'h48) ? 16'hA5A5 : 16'(i * 7 + 'h100);
  endfunction

  // Synchronous memory: 1-cycle read, 1-cycle write
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
    end else begin
      if (mem_wr) mem[mem_addr[8:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[8:0]];
    end
  end

  function automatic vec_t mk(input logic r, input logic [NR-1:0] q, input logic [NR-1:0] l,
                              input logic [NR-1:0] w, input logic [NR-1:0] g);
    vec_t v;
    v.rst = r; v.req = q; v.lock = l; v.wr = w; v.gnt = g;
    return v;
  endfunction

  function automatic void add(input logic r, input logic [NR-1:0] q, input logic [NR-1:0] l,
                              input logic [NR-1:0] w, input logic [NR-1:0] g);
    vecs.push_back(mk(r, q, l, w, g));
  endfunction

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, expv);
    end
  endtask

  // Drive one cycle of inputs, sample on the falling edge, update model
  task automatic run_cycle(input vec_t v, input bit full);
    int            w;
    sb_t           e;
    logic [NR-1:0] exp_rv;
    logic [WW-1:0] exp_rd, exp_a, exp_d;
    logic          exp_wr;
    reset  = v.rst;
    req    = v.req;
    lock   = v.lock;
    req_wr = v.wr;
    @(negedge clock);
    cyc++;
    seen_gnt = gnt;
    exp_rv = '0;
    exp_rd = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      exp_rv[e.who] = 1'b1;
      exp_rd = e.data;
    end
    chk("rvalid", WW'(rvalid), WW'(exp_rv));
    if (exp_rv != '0) chk("rdata", rdata, exp_rd);
    if (full) begin
      chk("gnt", WW'(gnt), WW'(v.gnt));
      w = -1;
      for (int i = 0; i < NR; i++) if (v.gnt[i]) w = i;
      exp_a  = '0;
      exp_d  = '0;
      exp_wr = 1'b0;
      if (!v.rst && w >= 0) begin
        exp_a  = addr_tab[w];
        exp_d  = wdata_tab[w];
        exp_wr = v.req[w] & v.wr[w];
        if (v.req[w]) begin
          if (v.wr[w]) exp_mem[addr_tab[w][8:0]] = wdata_tab[w];
          else sb.push_back('{due: cyc + 1, who: w, data: exp_mem[addr_tab[w][8:0]]});
        end
      end
      chk("mem_addr", mem_addr, exp_a);
      chk("mem_wdata", mem_wdata, exp_d);
      chk("mem_wr", WW'(mem_wr), WW'(exp_wr));
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    addr_tab[0]  = FB_BASE;      addr_tab[1]  = QTAB_BASE;
    addr_tab[2]  = QTAB_HI_BASE; addr_tab[3]  = 16'h0150;
    wdata_tab[0] = 16'h1111;     wdata_tab[1] = 16'h2222;
    wdata_tab[2] = 16'h3333;     wdata_tab[3] = 16'h1234;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*WW +: WW]  = addr_tab[i];
      req_wdata[i*WW +: WW] = wdata_tab[i];
    end
    for (int i = 0; i < 512; i++) exp_mem[i] = init_word(i);

    // Single read by requester 0 up to the burst limit, then a drop-release
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Round robin with all requesters reading
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    for (int r = 0; r < NR; r++) begin
      add(0, 4'b1111, 4'b0000, 4'b0000, 4'(1 << r));
      add(0, 4'b1111, 4'b0000, 4'b0000, 4'(1 << r));
      add(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    end
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Write by requester 3, read back, ungranted requester ignored
    add(0, 4'b1000, 4'b0000, 4'b1000, 4'b0000);
    add(0, 4'b1000, 4'b0000, 4'b1000, 4'b1000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b1010, 4'b0000, 4'b0010, 4'b1000);
    add(0, 4'b0010, 4'b0000, 4'b0010, 4'b1000);
    add(0, 4'b0010, 4'b0000, 4'b0010, 4'b0000);
    add(0, 4'b0010, 4'b0000, 4'b0010, 4'b0010);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Lock holds requester 1 for 20 accesses while 2 waits
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0110, 4'b0010, 4'b0000, 4'b0000);
    for (int r = 0; r < 20; r++) add(0, 4'b0110, 4'b0010, 4'b0000, 4'b0010);
    add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0010);
    add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // Reset during requester 2's read; requester 0 then wins
    add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    add(1, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    add(0, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    reset = 1'b1; req = '0; lock = '0; req_wr = '0;
    mem_init = 1'b1;
    @(posedge clock);
    #1;
    mem_init = 1'b0;

    foreach (vecs[i]) run_cycle(vecs[i], 1'b1);

    // Fairness: all requesters write; first grant times follow the rotation
    run_cycle(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000), 1'b1);
    for (int i = 0; i < NR; i++) first[i] = -1;
    for (int c = 0; c < 40; c++) begin
      run_cycle(mk(0, 4'b1111, 4'b0000, 4'b1111, 4'b0000), 1'b0);
      for (int i = 0; i < NR; i++) if (seen_gnt[i] && first[i] < 0) first[i] = c;
    end
    for (int i = 0; i < NR; i++) chk("first_grant", WW'(first[i]), WW'(1 + i * (MB + 1)));

    // Idle port after reset
    run_cycle(mk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000), 1'b0);
    for (int c = 0; c < 10; c++) run_cycle(mk(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000), 1'b1);

    chk("sb_drained", WW'(sb.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
